// File: rtl/requant_relu_q.sv
`default_nettype none
// ============================================================================
// Module      : requant_relu_q
// Description : Requantizes N signed ACC_W-bit sums to INT8 activations
//               (multiply, round-half-up shift, optional ReLU, saturate).
// Revision    : 1.0 - initial release
// ============================================================================
module requant_relu_q #(
  parameter int N     = 8,
  parameter int ACC_W = 32,
  parameter int M_W   = 16,
  parameter int OUT_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [N-1:0][ACC_W-1:0]       acc_in,
  input  logic [M_W-1:0]                mult,
  input  logic [5:0]                    shift,
  input  logic                          relu_en,
  output logic [N-1:0][OUT_W-1:0]       act_out,
  output logic [$clog2(N+1)-1:0]        sat_cnt,
  output logic                          done
);

  localparam int c_P_W   = ACC_W + M_W + 1;
  localparam int c_R_W   = c_P_W + 1;
  localparam int c_IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int c_CNT_W = $clog2(N + 1);
  localparam logic signed [c_R_W-1:0] c_MAX = c_R_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [c_R_W-1:0] c_MIN = -c_MAX - c_R_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;
  logic                       w_issue;
  logic [M_W-1:0]             r_mult;
  logic [5:0]                 r_shift;
  logic                       r_relu;
  logic [c_IDX_W-1:0]         r_idx;
  logic [c_IDX_W-1:0]         r_idx1;
  logic                       r_valid1;
  logic signed [c_P_W-1:0]    r_p;
  logic [N-1:0][OUT_W-1:0]    r_act;
  logic [c_CNT_W-1:0]         r_sat_cnt;
  logic                       r_done;

  logic signed [c_P_W-1:0]    w_acc_ext;
  logic signed [c_P_W-1:0]    w_mult_ext;
  logic signed [c_P_W-1:0]    w_prod;
  logic signed [c_R_W-1:0]    w_half;
  logic signed [c_R_W-1:0]    w_sum;
  logic signed [c_R_W-1:0]    w_r;
  logic signed [c_R_W-1:0]    w_relu;
  logic                       w_hi;
  logic                       w_lo;
  logic [OUT_W-1:0]           w_out;

  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN: begin
        w_issue = 1'b1;
        if (r_idx == c_IDX_W'(N - 1)) w_state_next = S_DRAIN;
      end
      S_DRAIN: w_state_next = S_DONE;
      S_DONE:  if (!start) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Stage 1 operands: the multiplier is zero-extended so the product stays signed.
  assign w_acc_ext  = {{(c_P_W - ACC_W){acc_in[r_idx][ACC_W-1]}}, acc_in[r_idx]};
  assign w_mult_ext = {{(c_P_W - M_W){1'b0}}, r_mult};
  assign w_prod     = w_acc_ext * w_mult_ext;

  // One extra bit of headroom keeps the rounding add from wrapping.
  assign w_half = (r_shift == 6'd0) ? '0 : (c_R_W'(1) << (r_shift - 6'd1));
  assign w_sum  = {r_p[c_P_W-1], r_p} + w_half;
  assign w_r    = w_sum >>> r_shift;
  assign w_relu = (r_relu && w_r[c_R_W-1]) ? '0 : w_r;
  assign w_hi   = (w_relu > c_MAX);
  assign w_lo   = (w_relu < c_MIN);
  assign w_out  = w_hi ? c_MAX[OUT_W-1:0] : (w_lo ? c_MIN[OUT_W-1:0] : w_relu[OUT_W-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mult    <= '0;
      r_shift   <= '0;
      r_relu    <= 1'b0;
      r_idx     <= '0;
      r_idx1    <= '0;
      r_valid1  <= 1'b0;
      r_p       <= '0;
      r_act     <= '0;
      r_sat_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_done   <= (r_state == S_DONE);
      r_valid1 <= w_issue;
      if (r_state == S_IDLE && start) begin
        r_mult    <= mult;
        r_shift   <= shift;
        r_relu    <= relu_en;
        r_idx     <= '0;
        r_sat_cnt <= '0;
      end
      if (w_issue) begin
        r_p    <= w_prod;
        r_idx1 <= r_idx;
        r_idx  <= r_idx + c_IDX_W'(1);
      end
      if (r_valid1) begin
        r_act[r_idx1] <= w_out;
        if (w_hi || w_lo) r_sat_cnt <= r_sat_cnt + c_CNT_W'(1);
      end
    end
  end

  assign act_out = r_act;
  assign sat_cnt = r_sat_cnt;
  assign done    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_requant_relu_q.sv
`default_nettype none
// ============================================================================
// Module      : tb_requant_relu_q
// Description : Self-checking bench for requant_relu_q (vectors + random).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_requant_relu_q;
  localparam int N = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [N-1:0][31:0]   acc_in;
  logic [15:0]          mult;
  logic [5:0]           shift;
  logic                 relu_en;
  logic [N-1:0][7:0]    act_out;
  logic [3:0]           sat_cnt;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  requant_relu_q #(.N(N), .ACC_W(32), .M_W(16), .OUT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .acc_in(acc_in), .mult(mult),
    .shift(shift), .relu_en(relu_en), .act_out(act_out), .sat_cnt(sat_cnt),
    .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][31:0] acc;
    logic [15:0]        mult;
    logic [5:0]         shift;
    bit                 relu;
    logic [N-1:0][7:0]  exp_act;
    int                 exp_sat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: exact integer arithmetic, floor((p + 2^(s-1)) / 2^s).
  function automatic logic [7:0] ref_elem(input logic [31:0] a, input logic [15:0] m,
                                          input logic [5:0] s, input bit relu, output bit sat);
    longint p;
    longint r;
    p = longint'($signed(a)) * longint'(m);
    if (s == 0) r = p;
    else        r = (p + (longint'(1) <<< (s - 1))) >>> s;
    if (relu && r < 0) r = 0;
    sat = 1'b0;
    if (r > 127)       begin r = 127;  sat = 1'b1; end
    else if (r < -128) begin r = -128; sat = 1'b1; end
    return r[7:0];
  endfunction

  task automatic model(output logic [N-1:0][7:0] ea, output int es);
    bit s;
    es = 0;
    for (int i = 0; i < N; i++) begin
      ea[i] = ref_elem(acc_in[i], mult, shift, relu_en, s);
      if (s) es++;
    end
  endtask

  task automatic run_check(input logic [N-1:0][7:0] exp_a, input int exp_s,
                           input bit scramble, input bit hold);
    logic [N-1:0][7:0] prev;
    int e;
    bit seen;
    prev = act_out;
    seen = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (e = 0; e < 40; e++) begin
      @(posedge clk);
      #1;
      if (e == 0 && scramble) begin
        mult    = 16'($urandom);
        shift   = 6'($urandom);
        relu_en = 1'($urandom);
      end
      if (e == 1) check("elem0_before_write", $signed(act_out[0]), $signed(prev[0]));
      if (e == 2) begin
        check("elem0_at_edge2", $signed(act_out[0]), $signed(exp_a[0]));
        check("last_elem_kept", $signed(act_out[N-1]), $signed(prev[N-1]));
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_latency", seen ? e : -1, N + 2);
    for (int i = 0; i < N; i++)
      check($sformatf("act_out[%0d]", i), $signed(act_out[i]), $signed(exp_a[i]));
    check("sat_cnt", sat_cnt, exp_s);
    if (!hold) begin
      @(negedge clk);
      start = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      check("done_fall", done, 0);
    end
  endtask

  task automatic apply_vec(input int k);
    acc_in  = vecs[k].acc;
    mult    = vecs[k].mult;
    shift   = vecs[k].shift;
    relu_en = vecs[k].relu;
  endtask

  initial begin
    logic [N-1:0][7:0] ea;
    int es;

    // T1: identity with saturation on two elements
    vecs[0].acc     = {32'd1, 32'd0, -32'd128, 32'd127, -32'd5, 32'd5, -32'd300, 32'd200};
    vecs[0].mult    = 16'd1;  vecs[0].shift = 6'd0;  vecs[0].relu = 1'b0;
    vecs[0].exp_act = {8'd1, 8'd0, 8'h80, 8'd127, 8'hFB, 8'd5, 8'h80, 8'd127};
    vecs[0].exp_sat = 2;
    // T2: round-half-up, ties toward +inf
    vecs[1].acc     = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd2, -32'd6, 32'd5};
    vecs[1].mult    = 16'd3;  vecs[1].shift = 6'd2;  vecs[1].relu = 1'b0;
    vecs[1].exp_act = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'hFC, 8'd4};
    vecs[1].exp_sat = 0;
    // T3: ReLU zeroing is not saturation
    vecs[2]         = vecs[1];
    vecs[2].relu    = 1'b1;
    vecs[2].exp_act = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd4};
    vecs[3].acc     = {N{-32'd1000000}};
    vecs[3].mult    = 16'd65535; vecs[3].shift = 6'd0; vecs[3].relu = 1'b1;
    vecs[3].exp_act = '0;
    vecs[3].exp_sat = 0;
    // T6: extremes; +max rounds to 128 and clamps, -max lands exactly on -128
    vecs[4].acc     = {32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'h80000000, 32'h7FFFFFFF};
    vecs[4].mult    = 16'd65535; vecs[4].shift = 6'd40; vecs[4].relu = 1'b0;
    vecs[4].exp_act = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'h80, 8'd127};
    vecs[4].exp_sat = 1;
    // shift=47: results collapse to 0 / -1
    vecs[5].acc     = {32'd0, 32'd0, 32'd0, 32'd1, -32'd1, -32'd1000, 32'd1000, 32'h80000000};
    vecs[5].mult    = 16'd65535; vecs[5].shift = 6'd47; vecs[5].relu = 1'b0;
    vecs[5].exp_act = {8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'hFF};
    vecs[5].exp_sat = 0;

    rst = 1'b1; start = 1'b0; acc_in = '0; mult = '0; shift = '0; relu_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_act_out", act_out, 0);
    check("reset_sat_cnt", sat_cnt, 0);
    check("reset_done", done, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 6; k++) begin
      apply_vec(k);
      run_check(vecs[k].exp_act, vecs[k].exp_sat, 1'b1, 1'b0);
    end

    // mult=0 forces all zeros with no saturation
    acc_in = {N{32'h7FFFFFFF}};
    acc_in[1] = 32'h80000000;
    mult = 16'd0; shift = 6'd0; relu_en = 1'b0;
    run_check('0, 0, 1'b0, 1'b0);

    // T4: hold start high after done; no rerun, then clean restart
    apply_vec(0);
    run_check(vecs[0].exp_act, vecs[0].exp_sat, 1'b0, 1'b1);
    acc_in = ~acc_in;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check("hold_done", done, 1);
      check("hold_act_out", act_out, vecs[0].exp_act);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("hold_done_fall", done, 0);
    model(ea, es);
    run_check(ea, es, 1'b0, 1'b0);

    // T5: reset mid-run with start still high
    apply_vec(1);
    @(negedge clk);
    start = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_rst_act_out", act_out, 0);
    check("midrun_rst_done", done, 0);
    check("midrun_rst_sat_cnt", sat_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      check("idle_after_rst_done", done, 0);
    end
    run_check(vecs[1].exp_act, vecs[1].exp_sat, 1'b0, 1'b0);

    // Randomized runs against the reference model
    for (int it = 0; it < 25; it++) begin
      for (int i = 0; i < N; i++)
        acc_in[i] = ($urandom_range(0, 1) == 1) ? 32'($urandom)
                                                : 32'($urandom_range(0, 4000)) - 32'd2000;
      mult    = ($urandom_range(0, 1) == 1) ? 16'($urandom) : 16'($urandom_range(0, 300));
      shift   = 6'($urandom_range(0, 47));
      relu_en = 1'($urandom);
      model(ea, es);
      run_check(ea, es, 1'(it % 2), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
